// File: rtl/kronos_mem_arbiter.sv
// Arbiter sharing one single-port memory bus between the Kronos fetch port and the LSU data port.
// Data (or instruction) priority with a bounded streak; one transaction outstanding at a time.
module kronos_mem_arbiter #(
    parameter int unsigned DATA_PRIORITY = 1,
    parameter int unsigned MAX_STREAK    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_ack,
    output logic [31:0] instr_data,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_rd_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data
);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

    localparam logic [3:0] StreakMax = 4'(MAX_STREAK);
    localparam bit         DataPrio  = (DATA_PRIORITY != 0);

    state_e     state_q;
    logic [3:0] streak_q;
    logic [3:0] streak_next;
    logic       arb_en;
    logic       cand_i;
    logic       cand_d;
    logic       grant_i;
    logic       grant_d;
    logic       np_req;
    logic       prio_grant;
    logic       np_grant;

    assign instr_ack    = mem_ack && (state_q == StGntI);
    assign data_ack     = mem_ack && (state_q == StGntD);
    assign instr_data   = mem_rd_data;
    assign data_rd_data = mem_rd_data;

    always_comb begin
        arb_en = (state_q == StIdle) || mem_ack;
        // The finishing side still holds req on its ack cycle, so it is masked out.
        cand_i = arb_en && instr_req && (state_q != StGntI);
        cand_d = arb_en && data_req && (state_q != StGntD);
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (cand_i && cand_d) begin
            grant_i = ((streak_q == StreakMax) == DataPrio);
            grant_d = !grant_i;
        end else begin
            grant_i = cand_i;
            grant_d = cand_d;
        end

        np_req     = DataPrio ? instr_req : data_req;
        prio_grant = DataPrio ? grant_d : grant_i;
        np_grant   = DataPrio ? grant_i : grant_d;

        streak_next = streak_q;
        if (np_grant) begin
            streak_next = 4'd0;
        end else if (prio_grant) begin
            if (!np_req) begin
                streak_next = 4'd0;
            end else if (streak_q >= StreakMax) begin
                streak_next = StreakMax;
            end else begin
                streak_next = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            streak_q    <= 4'd0;
            mem_req     <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wr_data <= 32'd0;
            mem_mask    <= 4'd0;
        end else begin
            streak_q <= streak_next;
            if (grant_i) begin
                state_q     <= StGntI;
                mem_req     <= 1'b1;
                mem_addr    <= instr_addr;
                mem_wr_en   <= 1'b0;
                mem_mask    <= 4'hF;
                mem_wr_data <= 32'd0;
            end else if (grant_d) begin
                state_q     <= StGntD;
                mem_req     <= 1'b1;
                mem_addr    <= data_addr;
                mem_wr_en   <= data_wr_en;
                mem_mask    <= data_mask;
                mem_wr_data <= data_wr_data;
            end else if (arb_en) begin
                state_q <= StIdle;
                mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed and randomized bench for kronos_mem_arbiter, checked against a transaction-level model.
module tb_kronos_mem_arbiter;

    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic        instr_ack;
    logic [31:0] instr_data;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic        data_ack;
    logic [31:0] data_rd_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_mask;
    logic        mem_wr_en;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rd_data;

    always #5 clk = ~clk;

    kronos_mem_arbiter #(
        .DATA_PRIORITY(1),
        .MAX_STREAK   (MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_addr  (instr_addr),
        .instr_req   (instr_req),
        .instr_ack   (instr_ack),
        .instr_data  (instr_data),
        .data_addr   (data_addr),
        .data_wr_data(data_wr_data),
        .data_mask   (data_mask),
        .data_wr_en  (data_wr_en),
        .data_req    (data_req),
        .data_ack    (data_ack),
        .data_rd_data(data_rd_data),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_mask    (mem_mask),
        .mem_wr_en   (mem_wr_en),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_rd_data (mem_rd_data)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the bus (0 none, 1 fetch, 2 data), streak, and the captured request.
    int          m_own = 0;
    int          m_streak = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wd = '0;
    logic [3:0]  m_mask = '0;
    logic        m_we = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks current outputs against the model, advances the model, then steps one clock.
    task automatic cycle();
        int g;
        bit ci;
        bit cd;
        #1;
        chk("mem_req", mem_req, m_own != 0);
        chk("instr_ack", instr_ack, mem_ack && m_own == 1);
        chk("data_ack", data_ack, mem_ack && m_own == 2);
        chk("instr_data", instr_data, mem_rd_data);
        chk("data_rd_data", data_rd_data, mem_rd_data);
        if (m_own != 0) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wr_data", mem_wr_data, m_wd);
            chk("mem_mask", mem_mask, m_mask);
            chk("mem_wr_en", mem_wr_en, m_we);
        end
        if (rst) begin
            m_own = 0;
            m_streak = 0;
            m_addr = '0;
            m_wd = '0;
            m_mask = '0;
            m_we = 1'b0;
        end else if (m_own == 0 || mem_ack) begin
            ci = instr_req && m_own != 1;
            cd = data_req && m_own != 2;
            if (ci && cd) g = (m_streak == MS) ? 1 : 2;
            else if (cd) g = 2;
            else if (ci) g = 1;
            else g = 0;
            if (g == 2) begin
                m_streak = instr_req ? ((m_streak >= MS) ? MS : m_streak + 1) : 0;
                m_addr = data_addr;
                m_wd = data_wr_data;
                m_mask = data_mask;
                m_we = data_wr_en;
            end else if (g == 1) begin
                m_streak = 0;
                m_addr = instr_addr;
                m_wd = '0;
                m_mask = 4'hF;
                m_we = 1'b0;
            end
            m_own = g;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit i_done;
        bit d_done;
        rst = 1'b1;
        instr_addr = '0;
        instr_req = 1'b0;
        data_addr = '0;
        data_wr_data = '0;
        data_mask = '0;
        data_wr_en = 1'b0;
        data_req = 1'b0;
        mem_ack = 1'b0;
        mem_rd_data = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wr_data", mem_wr_data, 32'h0);
        chk("rst_mem_mask", mem_mask, 4'h0);
        chk("rst_mem_wr_en", mem_wr_en, 1'b0);
        chk("rst_acks", {instr_ack, data_ack}, 2'b00);

        // Single fetch, ack two cycles after mem_req
        instr_req = 1'b1;
        instr_addr = 32'h100;
        cycle();
        chk("fetch_addr", mem_addr, 32'h100);
        chk("fetch_mask", mem_mask, 4'hF);
        chk("fetch_we", mem_wr_en, 1'b0);
        cycle();
        cycle();
        mem_ack = 1'b1;
        mem_rd_data = 32'hDEADBEEF;
        #1;
        chk("fetch_ack", instr_ack, 1'b1);
        chk("fetch_data", instr_data, 32'hDEADBEEF);
        chk("fetch_no_dack", data_ack, 1'b0);
        cycle();
        instr_req = 1'b0;
        mem_ack = 1'b0;
        cycle();

        // Store
        data_req = 1'b1;
        data_addr = 32'h2004;
        data_wr_data = 32'h55AA;
        data_mask = 4'b0011;
        data_wr_en = 1'b1;
        cycle();
        chk("store_addr", mem_addr, 32'h2004);
        chk("store_wd", mem_wr_data, 32'h55AA);
        chk("store_mask", mem_mask, 4'b0011);
        chk("store_we", mem_wr_en, 1'b1);
        mem_ack = 1'b1;
        #1;
        chk("store_ack", data_ack, 1'b1);
        cycle();
        data_req = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("store_idle", mem_req, 1'b0);
        cycle();

        // Contention: data first, then fetch with no gap
        instr_req = 1'b1;
        instr_addr = 32'h300;
        data_req = 1'b1;
        data_addr = 32'h400;
        data_wr_en = 1'b0;
        cycle();
        chk("cont_data_first", mem_addr, 32'h400);
        mem_ack = 1'b1;
        cycle();
        chk("cont_fetch_next", mem_addr, 32'h300);
        chk("cont_no_gap", mem_req, 1'b1);

        // Starvation bound: both held, ack latency 1
        for (int i = 0; i < 12; i++) begin
            mem_ack = (m_own != 0);
            cycle();
        end

        // Drive streak to MS, then both in IDLE must grant fetch
        instr_req = 1'b0;
        data_req = 1'b0;
        mem_ack = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            instr_req = 1'b1;
            data_req = 1'b1;
            mem_ack = 1'b0;
            cycle();
            instr_req = 1'b0;
            mem_ack = 1'b1;
            cycle();
        end
        instr_req = 1'b1;
        data_req = 1'b1;
        mem_ack = 1'b0;
        cycle();
        chk("streak_force", mem_addr, 32'h300);
        instr_req = 1'b0;
        data_req = 1'b0;
        mem_ack = 1'b1;
        cycle();

        // Spurious ack in IDLE
        #1;
        chk("spur_iack", instr_ack, 1'b0);
        chk("spur_dack", data_ack, 1'b0);
        cycle();
        mem_ack = 1'b0;
        #1;
        chk("spur_idle", mem_req, 1'b0);
        cycle();

        // Reset mid-transaction
        data_req = 1'b1;
        data_addr = 32'h888;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        data_req = 1'b0;
        #1;
        chk("rstmid_req", mem_req, 1'b0);
        chk("rstmid_addr", mem_addr, 32'h0);
        mem_ack = 1'b1;
        #1;
        chk("rstmid_late_ack", data_ack, 1'b0);
        cycle();
        mem_ack = 1'b0;

        // Randomized traffic
        i_done = 1'b0;
        d_done = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!instr_req || i_done) begin
                instr_req = ($urandom_range(0, 2) != 0);
                instr_addr = $urandom;
            end
            if (!data_req || d_done) begin
                data_req = ($urandom_range(0, 2) != 0);
                data_addr = $urandom;
                data_wr_data = $urandom;
                data_mask = 4'($urandom_range(0, 15));
                data_wr_en = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 199) == 0);
            mem_ack = (m_own != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            mem_rd_data = $urandom;
            i_done = mem_ack && m_own == 1;
            d_done = mem_ack && m_own == 2;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
